// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with sequential increment, stall,
// branch/jump load and call/return through a circular return-address stack.
// Priority per edge: reset > stall > ret > call > branch > increment.
// No handshake: every request is a single-cycle level sampled on the rising
// edge of clk. A request that loses arbitration, or arrives while stall is
// high, is dropped rather than held for a later cycle.
module pc_sequencer #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VEC = '0,
    parameter int unsigned          STEP      = 4,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             stall,
    input  logic                             branch_en,
    input  logic                             call_en,
    input  logic                             ret_en,
    input  logic [WIDTH-1:0]                 branch_target,
    output logic [WIDTH-1:0]                 pc_out,
    output logic [WIDTH-1:0]                 pc_plus,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             ras_err
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH+1);

    // Registered state. wr_ptr points at the slot the next push writes; when
    // the stack is full that slot holds the oldest entry, so an overflowing
    // push overwrites it and the pointer keeps advancing around the ring.
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [PTR_W-1:0] top_idx;
    logic             is_full;
    logic             is_empty;

    assign pc_plus   = pc_q + WIDTH'(STEP);
    assign top_idx   = wr_ptr_q - PTR_W'(1);
    assign is_full   = (count_q == CNT_W'(RAS_DEPTH));
    assign is_empty  = (count_q == '0);

    assign pc_out    = pc_q;
    assign ras_count = count_q;
    assign ras_full  = is_full;
    assign ras_empty = is_empty;
    assign ras_err   = err_q;

    // Next-state selection following the fixed action priority.
    always_comb begin
        pc_d      = pc_q;
        ras_mem_d = ras_mem_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        err_d     = 1'b0;
        if (stall) begin
            // Hold everything; requests this cycle are discarded.
        end else if (ret_en) begin
            if (is_empty) begin
                pc_d  = pc_plus;
                err_d = 1'b1;
            end else begin
                pc_d     = ras_mem_q[top_idx];
                wr_ptr_d = top_idx;
                count_d  = count_q - CNT_W'(1);
            end
        end else if (call_en) begin
            ras_mem_d[wr_ptr_q] = pc_plus;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            pc_d                = branch_target;
            if (is_full) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (branch_en) begin
            pc_d = branch_target;
        end else begin
            pc_d = pc_plus;
        end
    end

    // State registers with synchronous active-low reset; reset clears the RAS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_VEC;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            ras_mem_q <= ras_mem_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed vectors for pc_sequencer with the
// default parameters, plus a hand-written stall/return sequence.
module tb_pc_sequencer;

  localparam int W  = 32;
  localparam int CW = 3;

  // Clock/reset block
  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          branch_en;
  logic          call_en;
  logic          ret_en;
  logic [W-1:0]  branch_target;
  logic [W-1:0]  pc_out;
  logic [W-1:0]  pc_plus;
  logic [CW-1:0] ras_count;
  logic          ras_full;
  logic          ras_empty;
  logic          ras_err;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_en     (branch_en),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .branch_target (branch_target),
    .pc_out        (pc_out),
    .pc_plus       (pc_plus),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_err       (ras_err)
  );

  typedef struct {
    logic          rst_n;
    logic          stall;
    logic          branch_en;
    logic          call_en;
    logic          ret_en;
    logic [W-1:0]  target;
    logic [W-1:0]  exp_pc;
    logic [CW-1:0] exp_cnt;
    logic          exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic c, input logic rt, input logic [W-1:0] t,
                              input logic [W-1:0] epc, input logic [CW-1:0] ecnt,
                              input logic eerr);
    vec_t v;
    v.rst_n = r; v.stall = s; v.branch_en = b; v.call_en = c; v.ret_en = rt;
    v.target = t; v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_err = eerr;
    return v;
  endfunction

  // Scoreboard compare helper
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: apply one vector for one rising edge, then compare after the edge
  task automatic apply(input int idx, input vec_t v);
    logic [W-1:0] exp_plus;
    rst_n         = v.rst_n;
    stall         = v.stall;
    branch_en     = v.branch_en;
    call_en       = v.call_en;
    ret_en        = v.ret_en;
    branch_target = v.target;
    @(posedge clk);
    #1;
    exp_plus = v.exp_pc + 32'd4;
    check($sformatf("v%0d pc_out", idx),    pc_out,          v.exp_pc);
    check($sformatf("v%0d pc_plus", idx),   pc_plus,         exp_plus);
    check($sformatf("v%0d ras_count", idx), W'(ras_count),   W'(v.exp_cnt));
    check($sformatf("v%0d ras_full", idx),  W'(ras_full),    W'(v.exp_cnt == 3'd4));
    check($sformatf("v%0d ras_empty", idx), W'(ras_empty),   W'(v.exp_cnt == 3'd0));
    check($sformatf("v%0d ras_err", idx),   W'(ras_err),     W'(v.exp_err));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    branch_target = '0;

    //          rst  stl  br   call ret  target        exp_pc        cnt  err
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        3'd0, 0)); // reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h4,        3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h8,        3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'hC,        3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h10,       3'd0, 0));
    // nested call/return
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h100,      32'h100,      3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h104,      3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h200,      32'h200,      3'd2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h108,      3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h14,       3'd0, 0));
    // wrap
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        3'd0, 0));
    // back-to-back underflow
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h4,        3'd0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h8,        3'd0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'hC,        3'd0, 0));
    // overflow
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,        32'h0,        3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h100,      32'h100,      3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h200,      32'h200,      3'd2, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h300,      32'h300,      3'd3, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h400,      32'h400,      3'd4, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h500,      32'h500,      3'd4, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h404,      3'd3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h304,      3'd2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h204,      3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h104,      3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h108,      3'd0, 1));
    // stall drops a call
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h900,      32'h108,      3'd0, 0));
    // call+ret together, then branch+call together
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h40,       32'h40,       3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h80,       32'h80,       3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'h999,      32'h44,       3'd0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 32'h600,      32'h600,      3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h48,       3'd0, 0));
    // reset mid-operation with 3 entries at PC 0x200
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h10,       32'h10,       3'd1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h20,       32'h20,       3'd2, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h200,      32'h200,      3'd3, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h700,      32'h0,        3'd0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h4,        3'd0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h8,        3'd0, 0));

    @(negedge clk);
    foreach (vecs[i]) apply(i, vecs[i]);

    // Hand-written sequence: a stalled ret is dropped, RAS contents survive
    apply(100, mk(1, 0, 0, 1, 0, 32'h300, 32'h300, 3'd1, 0));
    for (int k = 0; k < 3; k++) begin
      apply(101 + k, mk(1, 1, 0, 0, 1, 32'h0, 32'h300, 3'd1, 0));
    end
    apply(104, mk(1, 0, 0, 0, 1, 32'h0, 32'hC, 3'd0, 0));
    apply(105, mk(1, 0, 0, 0, 0, 32'h0, 32'h10, 3'd0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the control unit. Replaces the bare PC register with a registered PC that supports sequential increment, stall, branch/jump load, and call/return through an internal return-address stack (RAS). It feeds instruction fetch directly and takes its redirect controls from the decode/branch logic.

## Interface
- WIDTH, 32: PC width in bits.
- RESET_VEC, 0: value loaded into the PC on reset, WIDTH bits.
- STEP, 4: sequential increment added each advancing cycle.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low: sampled only on the rising edge of clk.
- stall  in  1  hold PC and RAS this cycle.
- branch_en  in  1  load branch_target into the PC.
- call_en  in  1  push the return address (pc_out+STEP) and jump to branch_target.
- ret_en  in  1  pop the RAS top into the PC.
- branch_target  in  WIDTH  redirect address for branch and call.
- pc_out  out  WIDTH  registered current PC.
- pc_plus  out  WIDTH  combinational pc_out+STEP, modulo 2^WIDTH.
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.
- ras_err  out  1  registered one-cycle pulse on RAS overflow or underflow.

## Operation
- One action is taken per rising edge. Priority, highest first: reset > stall > ret_en > call_en > branch_en > increment.
- Reset (rst_n=0 at the edge):
  - pc_out=RESET_VEC, ras_count=0, ras_err=0.
  - All RAS entries are cleared to 0.
  - All other inputs are ignored.
- Stall: pc_out, RAS contents and ras_count hold. ras_err=0. Any call, ret or branch request is dropped, not queued.
- Ret, RAS not empty: pc_out takes the top entry and ras_count decrements.
- Ret, RAS empty (underflow):
  - pc_out=pc_plus (fall-through).
  - ras_count stays 0.
  - ras_err pulses.
- Call, RAS not full: pc_plus is pushed, ras_count increments, and pc_out=branch_target.
- Call, RAS full (overflow):
  - The oldest entry is discarded and the new entry is pushed (circular stack).
  - ras_count stays at RAS_DEPTH.
  - pc_out=branch_target.
  - ras_err pulses.
- ret_en and call_en together: ret is performed and call is ignored. This is not an error.
- branch_en together with call_en: call semantics apply; the target is the same.
- Branch: pc_out=branch_target. The RAS is unchanged.
- Otherwise: pc_out=pc_plus.
- Arithmetic: all additions are modulo 2^WIDTH, so the PC wraps silently with no flag. branch_target is loaded unmodified, with no alignment masking.
- The RAS is implemented as a circular buffer with a top pointer. Overflow advances the pointer, overwriting the oldest slot.

## Timing
- Latency from any input to pc_out is one clock: inputs are sampled at edge N and pc_out reflects them after edge N.
- pc_plus, ras_full and ras_empty are combinational from registered state. They have no input-to-output combinational path.
- ras_err is high for exactly the cycle following the offending edge. Back-to-back errors give consecutive pulses.
- The first rising edge with rst_n=1 performs a normal action from RESET_VEC. Reset asserted mid-sequence takes effect at that edge regardless of pending stall, call or ret.

## Test plan
- Reset, then 4 idle cycles (defaults) → pc_out 0x0, 0x4, 0x8, 0xC, 0x10.
- Wrap:
  - Branch to 0xFFFFFFFC, then one idle cycle → pc_out 0xFFFFFFFC, then 0x0.
  - ras_err stays 0 throughout.
- Nested call/return:
  - At PC 0x10, call to 0x100; at 0x104, call to 0x200.
  - Two rets return pc_out 0x108 then 0x14.
  - ras_count goes 1, 2, 1, 0.
- Overflow/underflow:
  - 5 calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 with RAS_DEPTH=4 → 5th call pulses ras_err and ras_count=4.
  - 4 rets yield 0x404, 0x304, 0x204, 0x104.
  - A 5th ret gives pc_out=pc_plus and pulses ras_err.
- Stall and simultaneous requests:
  - stall=1 with call_en=1 → pc_out and ras_count unchanged.
  - call_en and ret_en together with RAS holding 0x44 → pc_out=0x44 and ras_count decrements.
- Reset mid-operation: with RAS holding 3 entries at PC 0x200, pulse rst_n=0 for one edge → pc_out=0x0, ras_empty=1, ras_err=0.
